// File: rtl/vram_write_arbiter.sv
// Arbitrates the single VRAM write port between CPU stores and a linear fill engine.
// Define VRAM_ARB_FAIR_EN to force one fill slot after STARVE_LIM back-to-back CPU grants.
module vram_write_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 12,
    parameter int CELLS      = 4800,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] cur_reg, cur_next;
    logic [DATA_W-1:0] color_reg, color_next;
    logic              force_slot;
    logic              fill_issue;

    assign cpu_gnt = cpu_req & ~force_slot;

`ifdef VRAM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] starve_reg, starve_next;

    // Only meaningful while cells remain; the slot is spent on a real write.
    assign force_slot = (state_reg == FILL) && (cnt_reg != '0) && (starve_reg == SW'(STARVE_LIM));

    always_comb begin
        starve_next = '0;
        if ((state_reg == FILL) && (state_next == FILL) && cpu_gnt)
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_reg <= '0;
        else
            starve_reg <= starve_next;
    end
`else
    // Strict CPU priority: STARVE_LIM has no effect in this build.
    assign force_slot = 1'b0 && (STARVE_LIM != 0);
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cur_next   = cur_reg;
        color_next = color_reg;
        fill_issue = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fill_start) begin
                    state_next = FILL;
                    cnt_next   = (fill_len > CELLS_A) ? CELLS_A : fill_len;
                    cur_next   = (fill_base >= CELLS_A) ? fill_base - CELLS_A : fill_base;
                    color_next = fill_color;
                end
            end
            FILL: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else if (!cpu_gnt) begin
                    fill_issue = 1'b1;
                    cur_next   = (cur_reg + 1'b1 == CELLS_A) ? '0 : cur_reg + 1'b1;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cur_reg   <= '0;
            color_reg <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cur_reg   <= cur_next;
            color_reg <= color_next;
            // Status flags reflect the state being entered so they line up with it.
            fill_busy <= (state_next != IDLE);
            fill_done <= (state_next == DONE);
            vram_we   <= cpu_gnt | fill_issue;
            if (cpu_gnt) begin
                vram_addr <= cpu_addr;
                vram_data <= cpu_data;
            end else if (fill_issue) begin
                vram_addr <= cur_reg;
                vram_data <= color_reg;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: behavioural model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_vram_write_arbiter;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 12;
    localparam int CELLS      = 4800;
    localparam int STARVE_LIM = 8;
`ifdef VRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_data = '0;
    logic              fill_start = 1'b0;
    logic [ADDR_W-1:0] fill_base = '0;
    logic [ADDR_W-1:0] fill_len = '0;
    logic [DATA_W-1:0] fill_color = '0;
    logic              cpu_gnt, fill_busy, fill_done, vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;

    vram_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a fill is "active" while cells remain or the empty-count cycle is pending,
    // followed by a single "done" cycle.
    bit m_active = 0, m_done = 0;
    int m_left = 0, m_ptr = 0, m_color = 0, m_starve = 0;
    bit exp_we = 0;
    int exp_addr = 0, exp_data = 0;

    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic bit model_gnt();
        return cpu_req && !(FAIR && m_active && m_left > 0 && m_starve >= STARVE_LIM);
    endfunction

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_left = 0; m_ptr = 0; m_color = 0; m_starve = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0;
    endfunction

    function automatic void model_update();
        bit gnt;
        int left0;
        if (!rst) begin
            model_reset();
            return;
        end
        gnt   = model_gnt();
        left0 = m_left;
        if (gnt) begin
            exp_we = 1; exp_addr = int'(cpu_addr); exp_data = int'(cpu_data);
        end else if (m_active && m_left > 0) begin
            exp_we = 1; exp_addr = m_ptr; exp_data = m_color;
            m_ptr  = (m_ptr + 1) % CELLS;
            m_left = m_left - 1;
        end else begin
            exp_we = 0;
        end
        m_starve = (FAIR && m_active && left0 > 0 && gnt) ? m_starve + 1 : 0;
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (left0 == 0) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (fill_start) begin
            m_active = 1;
            m_left   = (int'(fill_len) > CELLS) ? CELLS : int'(fill_len);
            m_ptr    = (int'(fill_base) >= CELLS) ? int'(fill_base) - CELLS : int'(fill_base);
            m_color  = int'(fill_color);
        end
    endfunction

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("cpu_gnt", int'(cpu_gnt), int'(model_gnt()));
            check("vram_we", int'(vram_we), int'(exp_we));
            if (exp_we) begin
                check("vram_addr", int'(vram_addr), exp_addr);
                check("vram_data", int'(vram_data), exp_data);
            end
            check("fill_busy", int'(fill_busy), int'(m_active || m_done));
            check("fill_done", int'(fill_done), int'(m_done));
            if (vram_we) begin
                wr_addr.push_back(int'(vram_addr));
                wr_data.push_back(int'(vram_data));
                wr_cyc.push_back(cyc);
            end
            if (fill_done) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    endtask

    task automatic start_fill(input int base, input int len, input int color, output int c0);
        fill_base  = ADDR_W'(base);
        fill_len   = ADDR_W'(len);
        fill_color = DATA_W'(color);
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (fill_busy && n < limit) begin
            step();
            n++;
        end
        check("idle_timeout", int'(n >= limit), 0);
        step();
    endtask

    initial begin
        int c0, nfill, ncpu;
        model_reset();

        // Reset held with requests active: nothing may be written or reported.
        cpu_req = 1; cpu_addr = 13'd77; fill_start = 1; fill_len = 13'd5;
        repeat (6) step();
        check("rst_we", int'(vram_we), 0);
        check("rst_busy", int'(fill_busy), 0);
        check("rst_gnt_follows_req", int'(cpu_gnt), 1);
        cpu_req = 0; fill_start = 0; fill_len = '0;
        rst = 1;
        clear_logs();
        repeat (3) step();
        check("post_rst_busy", int'(fill_busy), 0);
        check("post_rst_no_writes", wr_addr.size(), 0);

        // Basic fill.
        clear_logs();
        start_fill(0, 4, 'hF00, c0);
        wait_idle(50);
        check("basic_count", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("basic_addr", qget(wr_addr, i), i);
            check("basic_data", qget(wr_data, i), 'hF00);
        end
        check("basic_first_delay", qget(wr_cyc, 0) - c0, 2);
        check("basic_done_count", done_cyc.size(), 1);
        check("basic_done_after_last", qget(done_cyc, 0) - qget(wr_cyc, 3), 1);

        // Wrap at the end of the grid.
        clear_logs();
        start_fill(4798, 4, 'h00F, c0);
        wait_idle(50);
        check("wrap_a0", qget(wr_addr, 0), 4798);
        check("wrap_a1", qget(wr_addr, 1), 4799);
        check("wrap_a2", qget(wr_addr, 2), 0);
        check("wrap_a3", qget(wr_addr, 3), 1);

        // Contention: CPU stores held for 20 cycles during a 3-cell fill.
        clear_logs();
        cpu_req = 1; cpu_addr = 13'd100; cpu_data = 12'h0F0;
        start_fill(10, 3, 'h00A, c0);
        repeat (19) step();
        cpu_req = 0;
        @(negedge clk); #1;
        nfill = 0; ncpu = 0;
        foreach (wr_addr[i]) if (wr_addr[i] == 100) ncpu++; else nfill++;
        check("contend_fill_writes", nfill, FAIR ? 2 : 0);
        check("contend_cpu_writes", ncpu, FAIR ? 18 : 20);
        wait_idle(50);
        nfill = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != 100) begin
            check("contend_fill_addr", wr_addr[i], 10 + nfill);
            nfill++;
        end
        check("contend_fill_total", nfill, 3);

        // Zero length.
        clear_logs();
        start_fill(50, 0, 'h111, c0);
        wait_idle(20);
        check("zero_no_writes", wr_addr.size(), 0);
        check("zero_done_delay", qget(done_cyc, 0) - c0, 2);

        // Second strobe during a fill is ignored.
        clear_logs();
        start_fill(20, 3, 'h123, c0);
        fill_base = 13'd200; fill_len = 13'd50; fill_start = 1;
        step();
        fill_start = 0;
        wait_idle(80);
        check("ignore_count", wr_addr.size(), 3);
        check("ignore_first", qget(wr_addr, 0), 20);
        check("ignore_last", qget(wr_addr, 2), 22);
        check("ignore_done_count", done_cyc.size(), 1);

        // Base above CELLS reduced once; length clamped to CELLS.
        clear_logs();
        start_fill(8000, 6000, 'hABC, c0);
        wait_idle(5000);
        check("clamp_count", wr_addr.size(), CELLS);
        check("clamp_first", qget(wr_addr, 0), 3200);
        check("clamp_last", qget(wr_addr, CELLS - 1), 3199);

        // Reset in the middle of a fill.
        clear_logs();
        start_fill(300, 10, 'h555, c0);
        nfill = 0;
        while (wr_addr.size() < 2 && nfill < 20) begin
            step();
            nfill++;
        end
        check("midrst_wait_timeout", int'(nfill >= 20), 0);
        rst = 0;
        model_reset();
        #1;
        check("midrst_we", int'(vram_we), 0);
        check("midrst_busy", int'(fill_busy), 0);
        check("midrst_addr", int'(vram_addr), 0);
        repeat (2) step();
        rst = 1;
        repeat (3) step();
        check("midrst_writes", wr_addr.size(), 2);
        check("midrst_no_done", done_cyc.size(), 0);
        clear_logs();
        start_fill(0, 2, 'h777, c0);
        wait_idle(20);
        check("midrst_next_count", wr_addr.size(), 2);
        check("midrst_next_a1", qget(wr_addr, 1), 1);
        check("midrst_next_done", done_cyc.size(), 1);

        // Randomised traffic; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            cpu_req    = ($urandom_range(0, 9) < 6);
            cpu_addr   = ADDR_W'($urandom_range(0, 8191));
            cpu_data   = DATA_W'($urandom);
            fill_start = ($urandom_range(0, 7) == 0);
            fill_base  = ADDR_W'($urandom_range(0, 8191));
            fill_len   = ADDR_W'($urandom_range(0, 24));
            fill_color = DATA_W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 0;
                model_reset();
                repeat (2) step();
                rst = 1;
            end
            step();
        end
        cpu_req = 0; fill_start = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Shares the single VRAM write port between the CPU store path and a hardware rectangle-free linear fill engine used for screen clears and line fills. It sits between the CPU's memory-mapped VRAM store logic and the VRAM write port, on the CPU clock domain. The VGA read port is untouched. The block grants the CPU on request, runs fills in the idle slots, and reports fill progress through a busy/done handshake.

## Interface
- ADDR_W, 13: VRAM cell address width (80x60 text grid).
- DATA_W, 12: cell colour width (4:4:4 RGB).
- CELLS, 4800: number of valid cells; addresses wrap modulo CELLS.
- STARVE_LIM, 8: consecutive CPU grants after which the fill engine is forced one slot (only with fairness compiled in).

- clk  in  1  CPU clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU store to VRAM pending this cycle.
- cpu_addr  in  ADDR_W  CPU store address.
- cpu_data  in  DATA_W  CPU store data.
- cpu_gnt  out  1  combinational; CPU store accepted this cycle.
- fill_start  in  1  one-cycle start strobe for a fill.
- fill_base  in  ADDR_W  first cell of fill, sampled with fill_start.
- fill_len  in  ADDR_W  cell count, sampled with fill_start.
- fill_color  in  DATA_W  fill value, sampled with fill_start.
- fill_busy  out  1  registered; fill in progress.
- fill_done  out  1  registered; one-cycle pulse at fill completion.
- vram_we  out  1  registered write enable.
- vram_addr  out  ADDR_W  registered write address.
- vram_data  out  DATA_W  registered write data.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: fill_start=1 latches base, min(fill_len, CELLS), colour; remaining count into cnt; next state FILL. fill_start in FILL or DONE is ignored.
- FILL: each cycle, if CPU not granted and cnt>0, issue fill write at cur addr, cur = (cur+1 == CELLS) ? 0 : cur+1, cnt-1. When cnt reaches 0 (including latched length 0), go DONE without writing.
- DONE: fill_done=1 for this cycle, next IDLE.
- fill_busy = 1 in FILL and DONE.
- Grant: cpu_gnt = cpu_req, except when a forced fill slot is active (see Configuration). A granted CPU store is written next edge; fill write in that cycle is suppressed and retried.
- Address arithmetic: fill base >= CELLS is reduced once by CELLS at latch; CPU addresses passed through unchecked.
- CPU stores are accepted in every state; the arbiter never drops a granted store.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt=0, starve counter=0, vram_we=0, vram_addr=0, vram_data=0, fill_busy=0, fill_done=0. cpu_gnt follows cpu_req combinationally even during reset, but vram_we stays 0 until release.
- Reset mid-fill aborts the fill; no fill_done pulse.
- Write latency: grant/issue at cycle N -> vram_we/addr/data valid during cycle N+1.
- fill_start at edge N -> fill_busy=1 from N+1; with no CPU traffic and length L>0, writes appear at N+2..N+L+1, fill_done at N+L+2, fill_busy=0 at N+L+3.
- Length 0: fill_done at N+2, no write.
- Simultaneous cpu_req and fill slot: CPU wins unless forced slot.

## Configuration
- VRAM_ARB_FAIR_EN defined: starve counter counts consecutive CPU grants while state is FILL; on reaching STARVE_LIM the next cycle withholds cpu_gnt, issues one fill write, clears the counter. Counter cleared on any non-granted cycle or leaving FILL.
- Not defined: strict CPU priority; fill can be starved indefinitely; no starve counter logic.

## Test plan
- Reset: hold rst=0 with cpu_req=1 and fill_start=1 -> vram_we=0, fill_busy=0, fill_done=0 throughout; after release IDLE.
- Basic fill: base 0, len 4, colour 0xF00, no CPU -> writes 0,1,2,3 with 0xF00 on consecutive cycles, single fill_done pulse one cycle after last write.
- Wrap: base 4798, len 4 -> write addresses 4798, 4799, 0, 1.
- Contention: fill len 3 with cpu_req held 20 cycles (addr 100, data 0x0F0) -> with VRAM_ARB_FAIR_EN fill writes occur in every 9th cycle and cpu_gnt drops in those cycles; without it, zero fill writes until cpu_req drops.
- Zero length and ignored start: len 0 -> fill_done two cycles after strobe, no vram_we; second fill_start during busy -> no effect on latched base/len.
- Reset mid-fill: assert rst after 2 of 10 writes -> outputs immediately zero, no fill_done, next fill starts cleanly.
